// File: rtl/threshold_chunk.sv
// One 8-bin slice of the threshold search: registers the absolute index of the
// highest-numbered bin with a strictly positive derivative, or 0 when none is.
module threshold_chunk #(
  parameter int TOP  = 1,
  parameter int BINS = 8,
  parameter int DW   = 17
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [BINS*DW-1:0] i_histogram_chunk,
  input  logic [7:0]         i_bin_index,
  output logic [7:0]         o_threshold
);

  localparam int KW = $clog2(BINS);

  logic          w_found;
  logic [KW-1:0] w_kmax;
  logic [7:0]    w_next;

  // TOP only selects waveform dumping in the standalone flow; nothing to build here.
  if (TOP != 0) begin : g_top
  end

  // Priority scan: ascending order so the highest positive bin overrides lower ones.
  always_comb begin
    w_found = 1'b0;
    w_kmax  = {KW{1'b0}};
    for (int k = 0; k < BINS; k++) begin
      // Strictly positive: sign bit clear and magnitude non-zero.
      if (!i_histogram_chunk[k*DW + DW - 1] && (|i_histogram_chunk[k*DW +: DW-1])) begin
        w_found = 1'b1;
        w_kmax  = KW'(k);
      end else begin
        w_found = w_found;
        w_kmax  = w_kmax;
      end
    end
  end

  // Absolute index with modulo-256 wrap; 0 doubles as "no positive bin".
  always_comb begin
    if (w_found) begin
      w_next = i_bin_index + {{(8-KW){1'b0}}, w_kmax};
    end else begin
      w_next = 8'd0;
    end
  end

  // Output register: one cycle of latency, cleared asynchronously by reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_threshold <= 8'd0;
    end else begin
      o_threshold <= w_next;
    end
  end

endmodule

// File: tb/tb_threshold_chunk.sv
// Self-checking bench for threshold_chunk: directed scenarios plus randomized
// vectors compared against a signed-arithmetic reference model.
module tb_threshold_chunk;

  logic         clk = 1'b0;
  logic         rst;
  logic [135:0] hist;
  logic [7:0]   base;
  logic [7:0]   thr;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  threshold_chunk #(.TOP(0), .BINS(8), .DW(17)) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_histogram_chunk (hist),
    .i_bin_index       (base),
    .o_threshold       (thr)
  );

  // Reference: walk bins from 7 down, first signed value above zero wins.
  function automatic logic [7:0] ref_thr(input logic [135:0] h, input logic [7:0] b);
    logic signed [16:0] s;
    for (int k = 7; k >= 0; k--) begin
      s = h[k*17 +: 17];
      if (s > 0) return 8'((int'(b) + k) % 256);
    end
    return 8'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [16:0] v);
    for (int k = 0; k < 8; k++) hist[k*17 +: 17] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_all(17'd5);
    base = 8'd16;
    #1;
    checks++;
    if (thr !== 8'd0) begin errors++; $display("FAIL reset_async got %0d want 0", thr); end
    repeat (2) tick();
    checks++;
    if (thr !== 8'd0) begin errors++; $display("FAIL reset_hold got %0d want 0", thr); end
    rst = 1'b0;
    #1;
    checks++;
    if (thr !== 8'd0) begin errors++; $display("FAIL reset_release_pre_edge got %0d want 0", thr); end
    tick();
    checks++;
    if (thr !== 8'd23) begin errors++; $display("FAIL reset_first_edge got %0d want 23", thr); end
  endtask

  task automatic test_single();
    set_all(17'd0);
    hist[3*17 +: 17] = 17'd1;
    base = 8'd40;
    #1;
    checks++;
    if (thr !== 8'd23) begin errors++; $display("FAIL single_not_same_edge got %0d want 23", thr); end
    tick();
    checks++;
    if (thr !== 8'd43) begin errors++; $display("FAIL single_bin3 got %0d want 43", thr); end
  endtask

  task automatic test_last_wins();
    set_all(17'd0);
    hist[1*17 +: 17] = 17'd100;
    hist[5*17 +: 17] = 17'd2;
    hist[6*17 +: 17] = 17'h1FFFD;
    base = 8'd8;
    tick();
    checks++;
    if (thr !== 8'd13) begin errors++; $display("FAIL last_wins_bin5 got %0d want 13", thr); end
    hist[7*17 +: 17] = 17'd1;
    tick();
    checks++;
    if (thr !== 8'd15) begin errors++; $display("FAIL last_wins_bin7 got %0d want 15", thr); end
  endtask

  task automatic test_no_positive();
    hist[0*17 +: 17] = 17'd0;
    hist[1*17 +: 17] = 17'h1FFFF;
    hist[2*17 +: 17] = 17'h10000;
    hist[3*17 +: 17] = 17'd0;
    hist[4*17 +: 17] = 17'h1FFF9;
    hist[5*17 +: 17] = 17'd0;
    hist[6*17 +: 17] = 17'd0;
    hist[7*17 +: 17] = 17'h1FFFF;
    base = 8'd200;
    tick();
    checks++;
    if (thr !== 8'd0) begin errors++; $display("FAIL no_positive got %0d want 0", thr); end
  endtask

  task automatic test_boundaries();
    set_all(17'd0);
    hist[0*17 +: 17] = 17'h0FFFF;
    base = 8'd248;
    tick();
    checks++;
    if (thr !== 8'd248) begin errors++; $display("FAIL bound_max_bin0 got %0d want 248", thr); end
    set_all(17'd0);
    hist[7*17 +: 17] = 17'd1;
    tick();
    checks++;
    if (thr !== 8'd255) begin errors++; $display("FAIL bound_bin7_255 got %0d want 255", thr); end
    base = 8'd252;
    tick();
    checks++;
    if (thr !== 8'd3) begin errors++; $display("FAIL bound_wrap got %0d want 3", thr); end
  endtask

  task automatic test_back_to_back();
    logic [135:0] vec [4];
    logic [7:0]   idx [4];
    logic [7:0]   want [4];
    logic [7:0]   prev;
    vec[0] = '0; vec[0][2*17 +: 17] = 17'h1FFFF;        idx[0] = 8'd64; want[0] = 8'd0;
    vec[1] = '0; vec[1][1*17 +: 17] = 17'd7;            idx[1] = 8'd8;  want[1] = 8'd9;
    vec[2] = '0; vec[2][7*17 +: 17] = 17'd300;
    vec[2][0*17 +: 17] = 17'd1;                         idx[2] = 8'd24; want[2] = 8'd31;
    vec[3] = '0; vec[3][0*17 +: 17] = 17'd2;            idx[3] = 8'd0;  want[3] = 8'd0;
    prev = thr;
    for (int i = 0; i < 4; i++) begin
      hist = vec[i];
      base = idx[i];
      #1;
      checks++;
      if (thr !== prev) begin errors++; $display("FAIL b2b_hold_%0d got %0d want %0d", i, thr, prev); end
      tick();
      checks++;
      if (thr !== want[i]) begin errors++; $display("FAIL b2b_out_%0d got %0d want %0d", i, thr, want[i]); end
      prev = want[i];
    end
    hist = vec[2];
    base = idx[2];
    tick();
    checks++;
    if (thr !== 8'd31) begin errors++; $display("FAIL b2b_reload got %0d want 31", thr); end
    hist = vec[1];
    base = idx[1];
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (thr !== 8'd0) begin errors++; $display("FAIL b2b_midreset_async got %0d want 0", thr); end
    tick();
    checks++;
    if (thr !== 8'd0) begin errors++; $display("FAIL b2b_midreset_hold got %0d want 0", thr); end
    rst = 1'b0;
    tick();
    checks++;
    if (thr !== 8'd9) begin errors++; $display("FAIL b2b_after_reset got %0d want 9", thr); end
  endtask

  task automatic test_random();
    logic [7:0] want;
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 8; k++) begin
        case ($urandom_range(0, 3))
          0: hist[k*17 +: 17] = 17'd0;
          1: hist[k*17 +: 17] = 17'($urandom_range(1, 65535));
          2: hist[k*17 +: 17] = 17'h10000 | 17'($urandom_range(0, 65535));
          default: hist[k*17 +: 17] = 17'($urandom);
        endcase
      end
      if ($urandom_range(0, 7) == 0) set_all(17'h1FFFF);
      base = 8'($urandom);
      want = ref_thr(hist, base);
      tick();
      checks++;
      if (thr !== want) begin
        errors++;
        $display("FAIL random_%0d got %0d want %0d", n, thr, want);
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    hist = '0;
    base = 8'd0;
    test_reset();
    test_single();
    test_last_wins();
    test_no_positive();
    test_boundaries();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/threshold_chunk.md
Name: threshold_chunk

Overview:
- Scans one 8-bin chunk of a signed 17-bit histogram-derivative vector.
- Reports the absolute bin index of the highest-numbered bin whose derivative is strictly positive, or 0 if the chunk has none.
- The parent threshold search instantiates 32 copies, one per 8-bin chunk of a 256-bin histogram.
- The parent then picks the last chunk with a non-zero result as the image threshold.

Parameters:
- TOP, 1, simulation-only. When 1, the block dumps its own waveforms; when 0 (as instantiated by the parent), no dump. No functional effect.
- BINS, 8, bins per chunk. Fixed at 8 for this design.
- DW, 17, width of each derivative sample (signed two's complement).

Ports:
- i_clk, input, 1, rising-edge clock.
- i_reset, input, 1, asynchronous, active-high reset.
- i_histogram_chunk, input, BINS*DW (136), packed derivatives. Bin k occupies bits [(k+1)*DW-1 : k*DW].
- i_bin_index, input, 8, absolute index of bin 0 of this chunk (chunk number × 8).
- o_threshold, output, 8, registered result: absolute index of the last positive bin, or 0.

Behaviour:
- Reset: while i_reset=1, o_threshold=0 immediately (asynchronous). It stays 0 until the first rising i_clk after reset deasserts.
- Interpret each bin d[k], k=0..7, as signed DW-bit. A bin is positive iff d[k] > 0:
  - zero is not positive;
  - any value with MSB set (e.g. 17'h10000 = -65536, 17'h1FFFF = -1) is not positive.
- Find k_max, the largest k with d[k] positive (priority on bin 7 down to bin 0).
- Next value:
  - if at least one bin is positive: i_bin_index + k_max, truncated to 8 bits (modulo-256 wrap);
  - if no bin is positive: 0.
- Selection logic is purely combinational from the inputs. o_threshold is a register updated on every rising edge of i_clk when not in reset.
- Latency: exactly 1 cycle; inputs sampled at edge N appear on o_threshold after edge N.
- There is no enable or handshake. The output continuously tracks the inputs with 1-cycle delay and holds between edges.
- Ambiguity: k_max=0 with i_bin_index=0 yields 0, the same as "none found". This is intentional; the parent treats 0 as "no threshold".
- Reset mid-operation: o_threshold clears asynchronously and the in-flight result is discarded. After release, the first edge loads the current inputs.
- X/unused: no internal state other than o_threshold.

Test Plan:
- Reset: assert i_reset with all bins = +5 and i_bin_index=16 -> o_threshold=0 without waiting for a clock edge. Deassert, clock once -> o_threshold=23.
- Single positive bin: d[3]=+1, all other bins 0, i_bin_index=40 -> o_threshold=43 one cycle later. It is not 43 on the same edge the inputs change.
- Last positive wins: d[1]=+100, d[5]=+2, d[6]=-3, d[7]=0, i_bin_index=8 -> o_threshold=13. Then set d[7]=+1 -> next cycle o_threshold=15.
- No positives: bins = {0, -1 (17'h1FFFF), -65536 (17'h10000), 0, -7, 0, 0, -1}, i_bin_index=200 -> o_threshold=0.
- Boundaries:
  - max positive 17'h0FFFF in bin 0 only, i_bin_index=248 -> 248;
  - bin 7 positive, i_bin_index=248 -> 255;
  - bin 7 positive, i_bin_index=252 -> 3 (wrap).
- Back-to-back: change the inputs every cycle over 4 cycles with expected values {0, 9, 31, 0} -> o_threshold follows exactly one cycle behind. Assert i_reset asynchronously in the middle of the sequence -> o_threshold=0 immediately.
